frog_controller: RTL

FROG_CONTROLLER -- requirements
Module: frog_controller

---
 rtl/frog_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/frog_controller.sv
// frog_controller: frog position, hop cooldown, death/respawn and game-over control
module frog_controller #(
  parameter int STEP         = 8,
  parameter int FROG_SIZE    = 8,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int START_X      = 316,
  parameter int START_Y      = 472,
  parameter int HOP_FRAMES   = 4,
  parameter int DEATH_FRAMES = 32,
  parameter int START_LIVES  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  input  logic       collision,
  output logic [9:0] frog_x,
  output logic [9:0] frog_y,
  output logic       frog_visible,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       win_pulse
);
  localparam int CMAX = HOP_FRAMES > DEATH_FRAMES ? HOP_FRAMES : DEATH_FRAMES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [9:0] MAX_X = 10'(SCREEN_W - FROG_SIZE);
  localparam logic [9:0] MAX_Y = 10'(SCREEN_H - FROG_SIZE);
  localparam logic [9:0] ST = 10'(STEP);
  typedef enum logic [1:0] {IDLE, HOP, DEAD, OVER} state_t;
  state_t state, state_n;
  logic [4:0] prev, btns, edges;
  logic [2:0] pend, pend_n, edge_pri, merged;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] blink, blink_n, lives_n;
  logic [9:0] x_n, y_n, mv_x, mv_y;
  logic vis, vis_n, win_n;
  assign btns = {btn_up, btn_down, btn_left, btn_right, btn_start};
  assign edges = btns & ~prev;
  // pending move codes rank by priority: 4 up, 3 down, 2 left, 1 right, 0 none
  assign edge_pri = edges[4] ? 3'd4 : edges[3] ? 3'd3 : edges[2] ? 3'd2 : edges[1] ? 3'd1 : 3'd0;
  assign merged = edge_pri > pend ? edge_pri : pend;
  // clamps compare in 11 bits so the sum cannot wrap before the limit test
  assign mv_x = merged == 3'd2 ? (frog_x < ST ? '0 : frog_x - ST) :
                merged == 3'd1 ? ({1'b0, frog_x} + {1'b0, ST} > {1'b0, MAX_X} ? MAX_X : frog_x + ST) : frog_x;
  assign mv_y = merged == 3'd4 ? (frog_y < ST ? '0 : frog_y - ST) :
                merged == 3'd3 ? ({1'b0, frog_y} + {1'b0, ST} > {1'b0, MAX_Y} ? MAX_Y : frog_y + ST) : frog_y;
  assign frog_visible = vis;
  assign game_over = state == OVER;
  // next-state: collision first, then moves, cooldown, death timer and restart
  always_comb begin
    state_n = state;
    x_n = frog_x;
    y_n = frog_y;
    lives_n = lives;
    vis_n = vis;
    win_n = 1'b0;
    cnt_n = cnt;
    blink_n = blink;
    pend_n = pend;
    if ((state == IDLE || state == HOP) && collision) begin
      state_n = DEAD;
      cnt_n = CW'(DEATH_FRAMES);
      blink_n = '0;
      vis_n = 1'b0;
      pend_n = '0;
    end else if (state == IDLE) begin
      pend_n = merged;
      if (frame_tick && merged != '0) begin
        x_n = mv_x;
        y_n = mv_y;
        pend_n = '0;
        cnt_n = CW'(HOP_FRAMES);
        state_n = HOP;
        win_n = mv_y == '0;
      end
    end else if (state == HOP) begin
      if (win_pulse) begin
        x_n = 10'(START_X);
        y_n = 10'(START_Y);
        state_n = IDLE;
      end else if (frame_tick) begin
        cnt_n = cnt - 1'b1;
        state_n = cnt == CW'(1) ? IDLE : HOP;
      end
    end else if (state == DEAD) begin
      if (frame_tick) begin
        cnt_n = cnt - 1'b1;
        blink_n = blink + 1'b1;
        vis_n = blink == 2'd3 ? ~vis : vis;
        if (cnt == CW'(1)) begin
          if (lives == 2'd1) begin
            lives_n = '0;
            vis_n = 1'b0;
            state_n = OVER;
          end else begin
            lives_n = lives - 1'b1;
            x_n = 10'(START_X);
            y_n = 10'(START_Y);
            vis_n = 1'b1;
            state_n = IDLE;
          end
        end
      end
    end else begin
      vis_n = 1'b0;
      if (edges[0]) begin
        lives_n = 2'(START_LIVES);
        x_n = 10'(START_X);
        y_n = 10'(START_Y);
        vis_n = 1'b1;
        state_n = IDLE;
      end
    end
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      frog_x <= 10'(START_X);
      frog_y <= 10'(START_Y);
      lives <= 2'(START_LIVES);
      vis <= 1'b1;
      win_pulse <= 1'b0;
      cnt <= '0;
      blink <= '0;
      pend <= '0;
      prev <= '0;
    end else begin
      state <= state_n;
      frog_x <= x_n;
      frog_y <= y_n;
      lives <= lives_n;
      vis <= vis_n;
      win_pulse <= win_n;
      cnt <= cnt_n;
      blink <= blink_n;
      pend <= pend_n;
      prev <= btns;
    end
  end
endmodule
